// File: rtl/link_tx_arb.sv
// link_tx_arb: transmit-side arbiter/sequencer for the link layer.
// Grants the PHY-bound TX mux to either the token/handshake stream (TO) or the
// link-layer data stream (LT), gates valid/ready of the non-granted source,
// masks the granted source after its EOP beat, and inserts an inter-packet gap
// once the PHY accepts the packet end.
// Optional watchdog: define LINK_TX_ARB_TIMEOUT_EN to abort packets that stay
// granted for TIMEOUT_CYCLES without tx_lp_eop_en.

module link_tx_arb #(
   parameter int IPG_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_W          = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tx_en,
   input  logic src_to_valid,
   input  logic src_to_sop,
   input  logic src_to_eop,
   output logic src_to_ready,
   input  logic src_lt_valid,
   input  logic src_lt_sop,
   input  logic src_lt_eop,
   output logic src_lt_ready,
   output logic tx_to_valid,
   output logic tx_lt_valid,
   input  logic tx_to_ready,
   input  logic tx_lt_ready,
   output logic tx_data_on,
   input  logic tx_lp_eop_en,
   output logic tx_busy,
   output logic tx_pkt_done,
   output logic tx_timeout
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TO_PKT = 2'd1,
      S_LT_PKT = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   // Gap counter preload; a zero gap skips the GAP state entirely.
   localparam logic [CNT_W-1:0] IPG_LOAD = (IPG_CYCLES > 0) ? CNT_W'(IPG_CYCLES - 1) : '0;
   localparam bit               IPG_SKIP = (IPG_CYCLES == 0);

   state_t           r_state;
   logic             r_last_lt;   // last-served pointer: 1 = LT was granted last
   logic             r_sent;      // granted source has completed its EOP beat
   logic             r_data_on;
   logic             r_busy;
   logic             r_pkt_done;
   logic [CNT_W-1:0] r_gap_cnt;

   logic w_req_to;
   logic w_req_lt;
   logic w_start;
   logic w_pick_to;
   logic w_in_pkt;
   logic w_to_grant;
   logic w_lt_grant;
   logic w_beat_eop;
   logic w_wdog_expire;
   logic w_pkt_end;

   // Requests are only the start of a packet; mid-packet beats never request.
   assign w_req_to  = src_to_valid & src_to_sop;
   assign w_req_lt  = src_lt_valid & src_lt_sop;
   assign w_start   = tx_en & (w_req_to | w_req_lt);
   // Round-robin between two: TO wins if alone, or on a tie when LT went last.
   assign w_pick_to = w_req_to & (~w_req_lt | r_last_lt);

   assign w_in_pkt   = (r_state == S_TO_PKT) || (r_state == S_LT_PKT);
   assign w_to_grant = (r_state == S_TO_PKT) && !r_sent;
   assign w_lt_grant = (r_state == S_LT_PKT) && !r_sent;

   // Pass-through gating straight from the registered grant: no beat latency.
   assign tx_to_valid  = w_to_grant & src_to_valid;
   assign src_to_ready = w_to_grant & tx_to_ready;
   assign tx_lt_valid  = w_lt_grant & src_lt_valid;
   assign src_lt_ready = w_lt_grant & tx_lt_ready;

   // EOP beat handshake of whichever source currently owns the mux.
   assign w_beat_eop = (w_to_grant & src_to_valid & tx_to_ready & src_to_eop) |
                       (w_lt_grant & src_lt_valid & tx_lt_ready & src_lt_eop);

   assign w_pkt_end = w_in_pkt & (tx_lp_eop_en | w_wdog_expire);

   assign tx_data_on  = r_data_on;
   assign tx_busy     = r_busy;
   assign tx_pkt_done = r_pkt_done;

   // Main sequencer: grant, packet, gap, with all status outputs registered.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_last_lt  <= 1'b1;
         r_sent     <= 1'b0;
         r_data_on  <= 1'b0;
         r_busy     <= 1'b0;
         r_pkt_done <= 1'b0;
         r_gap_cnt  <= '0;
      end else begin
         r_pkt_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_busy <= 1'b1;
                  r_sent <= 1'b0;
                  if (w_pick_to) begin
                     r_state   <= S_TO_PKT;
                     r_last_lt <= 1'b0;
                  end else begin
                     r_state   <= S_LT_PKT;
                     r_last_lt <= 1'b1;
                     r_data_on <= 1'b1;
                  end
               end
            end
            S_TO_PKT, S_LT_PKT: begin
               if (w_pkt_end) begin
                  // A watchdog abort ends the packet without a done pulse.
                  r_pkt_done <= tx_lp_eop_en;
                  r_sent     <= 1'b0;
                  r_data_on  <= 1'b0;
                  if (IPG_SKIP) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state   <= S_GAP;
                     r_gap_cnt <= IPG_LOAD;
                  end
               end else if (w_beat_eop) begin
                  r_sent <= 1'b1;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_data_on <= 1'b0;
            end
         endcase
      end
   end

`ifdef LINK_TX_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_wdog;
   logic             r_timeout;

   // Expiry on the last allowed cycle; a simultaneous PHY EOP wins.
   assign w_wdog_expire = w_in_pkt & ~tx_lp_eop_en & (r_wdog == WDOG_LAST);
   assign tx_timeout    = r_timeout;

   // Watchdog: counts granted cycles, held at zero outside the packet states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_wdog_expire;
         if (!w_in_pkt || w_pkt_end) begin
            r_wdog <= '0;
         end else begin
            r_wdog <= r_wdog + 1'b1;
         end
      end
   end
`else
   assign w_wdog_expire = 1'b0;
   assign tx_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_link_tx_arb.sv
// tb_link_tx_arb: self-checking bench for link_tx_arb.
// Expected grant order is queued when requests are raised and popped when the
// DUT shows a grant. Outputs are sampled on the falling clock edge.

module tb_link_tx_arb;

   localparam int IPG = 2;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic tx_en;
   logic src_to_valid, src_to_sop, src_to_eop, src_to_ready;
   logic src_lt_valid, src_lt_sop, src_lt_eop, src_lt_ready;
   logic tx_to_valid, tx_lt_valid;
   logic tx_to_ready, tx_lt_ready;
   logic tx_data_on;
   logic tx_lp_eop_en;
   logic tx_busy, tx_pkt_done, tx_timeout;

   int n_checks = 0;
   int n_errors = 0;
   bit q_exp[$];   // expected grant sequence: 0 = TO, 1 = LT

   link_tx_arb #(
      .IPG_CYCLES     (IPG),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (10)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_en        (tx_en),
      .src_to_valid (src_to_valid),
      .src_to_sop   (src_to_sop),
      .src_to_eop   (src_to_eop),
      .src_to_ready (src_to_ready),
      .src_lt_valid (src_lt_valid),
      .src_lt_sop   (src_lt_sop),
      .src_lt_eop   (src_lt_eop),
      .src_lt_ready (src_lt_ready),
      .tx_to_valid  (tx_to_valid),
      .tx_lt_valid  (tx_lt_valid),
      .tx_to_ready  (tx_to_ready),
      .tx_lt_ready  (tx_lt_ready),
      .tx_data_on   (tx_data_on),
      .tx_lp_eop_en (tx_lp_eop_en),
      .tx_busy      (tx_busy),
      .tx_pkt_done  (tx_pkt_done),
      .tx_timeout   (tx_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d of %0d", n_errors, n_checks);
      $fatal(1);
   end

   task automatic drive_src(input bit lt, input bit v, input bit sop, input bit eop);
      if (lt) begin
         src_lt_valid = v;
         src_lt_sop   = sop;
         src_lt_eop   = eop;
      end else begin
         src_to_valid = v;
         src_to_sop   = sop;
         src_to_eop   = eop;
      end
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      tx_en        = 1'b0;
      tx_to_ready  = 1'b0;
      tx_lt_ready  = 1'b0;
      tx_lp_eop_en = 1'b0;
      drive_src(1'b0, 1'b0, 1'b0, 1'b0);
      drive_src(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n       = 1'b1;
      tx_en       = 1'b1;
      tx_to_ready = 1'b1;
      tx_lt_ready = 1'b1;
      q_exp.delete();
   endtask

   // Bounded wait for either gated valid to appear; waited = -1 on expiry.
   task automatic wait_grant(output bit lt, output int waited);
      waited = -1;
      lt     = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (tx_to_valid || tx_lt_valid) begin
            waited = i;
            lt     = tx_lt_valid;
            break;
         end
      end
   endtask

   // Scoreboard pop point: compare the observed grant with the queued one.
   task automatic expect_grant(input string name, input int exp_wait);
      bit lt;
      bit exp_lt;
      int waited;
      wait_grant(lt, waited);
      exp_lt = (q_exp.size() > 0) ? q_exp.pop_front() : 1'b0;
      n_checks++;
      if (waited < 0) begin
         n_errors++;
         $display("FAIL %s: no grant within 40 cycles, required src=%0d", name, exp_lt);
      end else begin
         if (lt !== exp_lt) begin
            n_errors++;
            $display("FAIL %s: granted src=%0d, required src=%0d", name, lt, exp_lt);
         end
         n_checks++;
         if (tx_data_on !== exp_lt) begin
            n_errors++;
            $display("FAIL %s_data_on: got %b, required %b", name, tx_data_on, exp_lt);
         end
         if (exp_wait >= 0) begin
            n_checks++;
            if (waited !== exp_wait) begin
               n_errors++;
               $display("FAIL %s_latency: got %0d cycles, required %0d", name, waited, exp_wait);
            end
         end
      end
   endtask

   // Called with the grant visible; streams beats, checks EOP lockout, ends via PHY EOP.
   task automatic stream_packet(input string name, input bit lt, input int beats,
                                input bit rearm, input int lag);
      for (int b = 0; b < beats; b++) begin
         drive_src(lt, 1'b1, (b == 0), (b == beats - 1));
         #1;
         n_checks++;
         if ((lt ? tx_lt_valid : tx_to_valid) !== 1'b1 || tx_data_on !== lt ||
             (lt ? src_to_ready : src_lt_ready) !== 1'b0 ||
             (lt ? tx_to_valid : tx_lt_valid) !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_beat%0d: own_v=%b data_on=%b other_rdy=%b other_v=%b, required 1 %b 0 0",
                     name, b, (lt ? tx_lt_valid : tx_to_valid), tx_data_on,
                     (lt ? src_to_ready : src_lt_ready), (lt ? tx_to_valid : tx_lt_valid), lt);
         end
         @(negedge clk);
      end
      drive_src(lt, rearm, rearm, 1'b0);
      #1;
      for (int k = 0; k <= lag; k++) begin
         if (k > 0) @(negedge clk);
         n_checks++;
         if ((lt ? tx_lt_valid : tx_to_valid) !== 1'b0 || (lt ? src_lt_ready : src_to_ready) !== 1'b0 ||
             tx_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_lockout%0d: own_v=%b own_rdy=%b busy=%b, required 0 0 1", name, k,
                     (lt ? tx_lt_valid : tx_to_valid), (lt ? src_lt_ready : src_to_ready), tx_busy);
         end
      end
      tx_lp_eop_en = 1'b1;
      @(negedge clk);
      tx_lp_eop_en = 1'b0;
      n_checks++;
      if (tx_pkt_done !== 1'b1 || tx_data_on !== 1'b0 || tx_busy !== 1'b1 ||
          tx_to_valid !== 1'b0 || tx_lt_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL %s_end: done=%b data_on=%b busy=%b to_v=%b lt_v=%b, required 1 0 1 0 0",
                  name, tx_pkt_done, tx_data_on, tx_busy, tx_to_valid, tx_lt_valid);
      end
      @(negedge clk);
      n_checks++;
      if (tx_pkt_done !== 1'b0) begin
         n_errors++;
         $display("FAIL %s_done_width: done=%b one cycle later, required 0", name, tx_pkt_done);
      end
   endtask

   task automatic test_reset();
      tx_en        = 1'b1;
      tx_to_ready  = 1'b1;
      tx_lt_ready  = 1'b1;
      tx_lp_eop_en = 1'b1;
      drive_src(1'b0, 1'b1, 1'b1, 1'b1);
      drive_src(1'b1, 1'b1, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({tx_busy, tx_data_on, tx_pkt_done, tx_timeout, tx_to_valid, tx_lt_valid,
           src_to_ready, src_lt_ready} !== 8'b0) begin
         n_errors++;
         $display("FAIL reset_async: outputs=%b, required 00000000",
                  {tx_busy, tx_data_on, tx_pkt_done, tx_timeout, tx_to_valid, tx_lt_valid,
                   src_to_ready, src_lt_ready});
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({tx_busy, tx_data_on, tx_pkt_done, tx_timeout, tx_to_valid, tx_lt_valid,
           src_to_ready, src_lt_ready} !== 8'b0) begin
         n_errors++;
         $display("FAIL reset_held: outputs=%b, required 00000000",
                  {tx_busy, tx_data_on, tx_pkt_done, tx_timeout, tx_to_valid, tx_lt_valid,
                   src_to_ready, src_lt_ready});
      end
   endtask

   task automatic test_token_packet();
      do_reset();
      drive_src(1'b0, 1'b1, 1'b1, 1'b0);
      q_exp.push_back(1'b0);
      expect_grant("tok_grant", 1);
      stream_packet("tok_pkt", 1'b0, 2, 1'b1, 0);
      q_exp.push_back(1'b0);
      expect_grant("tok_regrant_gap", IPG);
      stream_packet("tok_pkt2", 1'b0, 1, 1'b0, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_round_robin();
      do_reset();
      drive_src(1'b0, 1'b1, 1'b1, 1'b0);
      drive_src(1'b1, 1'b1, 1'b1, 1'b0);
      q_exp.push_back(1'b0);
      q_exp.push_back(1'b1);
      q_exp.push_back(1'b0);
      q_exp.push_back(1'b1);
      for (int i = 0; i < 4; i++) begin
         bit src;
         src = i[0];
         expect_grant($sformatf("rr_grant%0d", i), (i == 0) ? 1 : IPG);
         stream_packet($sformatf("rr_pkt%0d", i), src, 2, (i < 3), 0);
      end
      drive_src(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (tx_busy !== 1'b0) begin
         n_errors++;
         $display("FAIL rr_idle: busy=%b, required 0", tx_busy);
      end
   endtask

   task automatic test_eop_lockout();
      drive_src(1'b1, 1'b1, 1'b1, 1'b0);
      q_exp.push_back(1'b1);
      expect_grant("lk_grant", 1);
      stream_packet("lk_pkt", 1'b1, 3, 1'b1, 2);
      q_exp.push_back(1'b1);
      expect_grant("lk_regrant_gap", IPG);
      stream_packet("lk_pkt2", 1'b1, 1, 1'b0, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_tx_en();
      tx_en = 1'b0;
      drive_src(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (tx_busy !== 1'b0 || tx_to_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL en_blocked%0d: busy=%b to_v=%b, required 0 0", i, tx_busy, tx_to_valid);
         end
      end
      tx_en = 1'b1;
      q_exp.push_back(1'b0);
      expect_grant("en_grant", 1);
      tx_en = 1'b0;
      stream_packet("en_pkt", 1'b0, 2, 1'b1, 0);
      repeat (6) @(negedge clk);
      n_checks++;
      if (tx_busy !== 1'b0 || tx_to_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL en_drop_idle: busy=%b to_v=%b, required 0 0", tx_busy, tx_to_valid);
      end
      drive_src(1'b0, 1'b0, 1'b0, 1'b0);
      tx_en = 1'b1;
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      drive_src(1'b1, 1'b1, 1'b1, 1'b0);
      q_exp.push_back(1'b1);
      expect_grant("rst_grant", 1);
      @(negedge clk);
      drive_src(1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (tx_data_on !== 1'b1 || tx_lt_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_pre: data_on=%b lt_v=%b, required 1 1", tx_data_on, tx_lt_valid);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({tx_data_on, tx_lt_valid, src_lt_ready, tx_busy} !== 4'b0) begin
         n_errors++;
         $display("FAIL rst_mid_pkt: data_on/lt_v/lt_rdy/busy=%b, required 0000",
                  {tx_data_on, tx_lt_valid, src_lt_ready, tx_busy});
      end
      drive_src(1'b0, 1'b1, 1'b1, 1'b0);
      drive_src(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      q_exp.push_back(1'b0);
      expect_grant("rst_first_to", 1);
      stream_packet("rst_to_pkt", 1'b0, 1, 1'b0, 0);
      q_exp.push_back(1'b1);
      expect_grant("rst_then_lt", IPG);
      stream_packet("rst_lt_pkt", 1'b1, 1, 1'b0, 0);
      repeat (2) @(negedge clk);
   endtask

`ifdef LINK_TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int seen;
      do_reset();
      drive_src(1'b1, 1'b1, 1'b1, 1'b0);
      q_exp.push_back(1'b1);
      expect_grant("wd_grant", 1);
      drive_src(1'b1, 1'b1, 1'b0, 1'b0);
      seen = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (tx_timeout === 1'b1) begin
            seen = i;
            break;
         end
      end
      n_checks++;
      if (seen !== TMO) begin
         n_errors++;
         $display("FAIL wd_expiry: timeout after %0d cycles, required %0d", seen, TMO);
      end
      n_checks++;
      if (tx_data_on !== 1'b0 || tx_pkt_done !== 1'b0 || tx_busy !== 1'b1 || tx_lt_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL wd_abort: data_on=%b done=%b busy=%b lt_v=%b, required 0 0 1 0",
                  tx_data_on, tx_pkt_done, tx_busy, tx_lt_valid);
      end
      drive_src(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (tx_timeout !== 1'b0 || tx_busy !== 1'b1) begin
         n_errors++;
         $display("FAIL wd_gap: timeout=%b busy=%b, required 0 1", tx_timeout, tx_busy);
      end
      @(negedge clk);
      n_checks++;
      if (tx_busy !== 1'b0) begin
         n_errors++;
         $display("FAIL wd_idle: busy=%b, required 0", tx_busy);
      end
   endtask
`else
   task automatic test_timeout();
      int hits;
      do_reset();
      drive_src(1'b1, 1'b1, 1'b1, 1'b0);
      q_exp.push_back(1'b1);
      expect_grant("nowd_grant", 1);
      drive_src(1'b1, 1'b1, 1'b0, 1'b0);
      hits = 0;
      for (int i = 0; i < 3 * TMO; i++) begin
         @(negedge clk);
         if (tx_timeout !== 1'b0) hits++;
      end
      n_checks++;
      if (hits != 0 || tx_busy !== 1'b1 || tx_data_on !== 1'b1) begin
         n_errors++;
         $display("FAIL nowd_hold: timeout_hits=%0d busy=%b data_on=%b, required 0 1 1",
                  hits, tx_busy, tx_data_on);
      end
      drive_src(1'b1, 1'b0, 1'b0, 1'b0);
      tx_lp_eop_en = 1'b1;
      @(negedge clk);
      tx_lp_eop_en = 1'b0;
      n_checks++;
      if (tx_pkt_done !== 1'b1 || tx_data_on !== 1'b0) begin
         n_errors++;
         $display("FAIL nowd_end: done=%b data_on=%b, required 1 0", tx_pkt_done, tx_data_on);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (tx_busy !== 1'b0) begin
         n_errors++;
         $display("FAIL nowd_idle: busy=%b, required 0", tx_busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_token_packet();
      test_round_robin();
      test_eop_lockout();
      test_tx_en();
      test_reset_mid_packet();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
